// File: rtl/rv_mem_arb_pkg.sv
// Shared types for the core/DMA memory-port arbiter.
package rv_mem_arb_pkg;

  // Arbiter mode: free arbitration, or DMA holding the port for a burst.
  typedef enum logic {
    IDLE      = 1'b0,
    DMA_BURST = 1'b1
  } arb_state_t;

  // Requester that owns an access (used for fairness and read-return routing).
  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_t;

endpackage

// File: rtl/rv_rtag_pipe.sv
// Read-return tag pipe: carries {valid, owner} alongside the memory read latency.
module rv_rtag_pipe
  import rv_mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   valid_i,
  input  owner_t owner_i,
  output logic   valid_o,
  output owner_t owner_o
);

  logic [MEM_LAT-1:0] valid_q, valid_d;
  logic [MEM_LAT-1:0] owner_q, owner_d;

  // Shift the tags one stage per cycle; stage 0 takes the newly issued access.
  always_comb begin
    valid_d    = valid_q;
    owner_d    = owner_q;
    valid_d[0] = valid_i;
    owner_d[0] = owner_i;
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      owner_d[i] = owner_q[i-1];
    end
  end

  // Tag registers; reset drops every in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign valid_o = valid_q[MEM_LAT-1];
  assign owner_o = owner_t'(owner_q[MEM_LAT-1]);

endmodule

// File: rtl/rv_mem_arb.sv
// Core/DMA arbiter for a single synchronous memory port, with read-data return routing.
module rv_mem_arb
  import rv_mem_arb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic          dma_last,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned   CntW   = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  arb_state_t      state_q, state_d;
  owner_t          last_owner_q, last_owner_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            core_win, dma_win;
  logic            tag_valid;
  owner_t          tag_owner;

  assign cnt_inc = burst_cnt_q + CntW'(1);

  // Grant decision: burst ownership first, then round-robin on a tie.
  always_comb begin
    core_win = 1'b0;
    dma_win  = 1'b0;
    if (!rst) begin
      if (state_q == DMA_BURST) begin
        // Core only gets in on a cycle the DMA leaves idle, which also ends the burst.
        dma_win  = dma_req;
        core_win = core_req && !dma_req;
      end else if (core_req && dma_req) begin
        core_win = (last_owner_q == OWN_DMA);
        dma_win  = (last_owner_q == OWN_CORE);
      end else begin
        core_win = core_req;
        dma_win  = dma_req;
      end
    end
  end

  // Next state: burst entry/exit, beat counting and last-owner tracking.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    if (core_win) last_owner_d = OWN_CORE;
    if (dma_win)  last_owner_d = OWN_DMA;

    unique case (state_q)
      IDLE: begin
        if (dma_win && !dma_last && (MAX_BURST > 1)) begin
          state_d     = DMA_BURST;
          burst_cnt_d = CntW'(1);
        end
      end
      DMA_BURST: begin
        // last_owner is already DMA here unless the core slips in on the exit cycle.
        if (!dma_req) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = cnt_inc;
          if (dma_last || (cnt_inc == MaxCnt)) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Arbiter state registers; reset lets the core win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_DMA;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // Memory-side mux driven by the winner of this cycle.
  always_comb begin
    mem_en    = core_win || dma_win;
    mem_we    = (core_win && core_we) || (dma_win && dma_we);
    mem_addr  = dma_win ? dma_addr : core_addr;
    mem_wdata = dma_win ? dma_wdata : core_wdata;
  end

  assign core_gnt = core_win;
  assign dma_gnt  = dma_win;

  rv_rtag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rtag_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (mem_en && !mem_we),
    .owner_i (dma_win ? OWN_DMA : OWN_CORE),
    .valid_o (tag_valid),
    .owner_o (tag_owner)
  );

  // Read-return demux: data is broadcast, valid goes only to the owner.
  always_comb begin
    core_rvalid = tag_valid && (tag_owner == OWN_CORE);
    dma_rvalid  = tag_valid && (tag_owner == OWN_DMA);
    core_rdata  = mem_rdata;
    dma_rdata   = mem_rdata;
  end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench: two arbiters (MEM_LAT 1 and 3) share stimulus and are checked against one model.
module tb_rv_mem_arb;

  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        core_req, core_we, dma_req, dma_we, dma_last;
  logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata;

  logic        a_cg, a_crv, a_dg, a_drv, a_en, a_we;
  logic [31:0] a_crd, a_drd, a_addr, a_wdata, a_mrd;
  logic        b_cg, b_crv, b_dg, b_drv, b_en, b_we;
  logic [31:0] b_crd, b_drd, b_addr, b_wdata, b_mrd;

  rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_BURST(MAXB)) u_dut_a (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(a_cg), .core_rvalid(a_crv), .core_rdata(a_crd),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(a_dg), .dma_rvalid(a_drv), .dma_rdata(a_drd),
    .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_mrd)
  );

  rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_BURST(MAXB)) u_dut_b (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(b_cg), .core_rvalid(b_crv), .core_rdata(b_crd),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(b_dg), .dma_rvalid(b_drv), .dma_rdata(b_drd),
    .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_mrd)
  );

  // Memory contents are a fixed function of address; 0x100 holds 0xDEADBEEF.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory responders: data appears exactly MEM_LAT cycles after a read strobe, junk otherwise.
  logic        ra_v = 1'b0;
  logic [31:0] ra_a = '0;
  logic [2:0]  rb_v = '0;
  logic [31:0] rb_a [3];
  always @(posedge clk) begin
    ra_v  <= a_en && !a_we;
    ra_a  <= a_addr;
    rb_v  <= {rb_v[1:0], b_en && !b_we};
    rb_a[0] <= b_addr;
    rb_a[1] <= rb_a[0];
    rb_a[2] <= rb_a[1];
  end
  assign a_mrd = ra_v ? mem_val(ra_a) : 32'hBAD0BAD0;
  assign b_mrd = rb_v[2] ? mem_val(rb_a[2]) : 32'hBAD0BAD0;

  // Reference model state.
  typedef struct packed {
    int          due;
    logic        dma;
    logic [31:0] addr;
  } ret_t;
  ret_t qa[$];
  ret_t qb[$];
  bit   m_burst, m_last_dma;
  int   m_beats, cyc;
  bit   e_cg, e_dg;
  int   n_checks, n_fail;
  logic obs_cg, obs_dg, obs_crv, obs_drv;
  logic [31:0] obs_crd;
  int   cnt_bc, cnt_bd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Who should be granted this cycle, from the arbitration rules.
  task automatic model_gnt();
    e_cg = 1'b0;
    e_dg = 1'b0;
    if (!rst) begin
      if (m_burst) begin
        e_dg = dma_req;
        e_cg = core_req && !dma_req;
      end else if (core_req && dma_req) begin
        e_cg = m_last_dma;
        e_dg = !m_last_dma;
      end else begin
        e_cg = core_req;
        e_dg = dma_req;
      end
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_burst = 0; m_beats = 0; m_last_dma = 1;
      qa.delete(); qb.delete();
      return;
    end
    if (e_cg && !core_we) begin
      qa.push_back('{due: cyc + 1, dma: 1'b0, addr: core_addr});
      qb.push_back('{due: cyc + 3, dma: 1'b0, addr: core_addr});
    end
    if (e_dg && !dma_we) begin
      qa.push_back('{due: cyc + 1, dma: 1'b1, addr: dma_addr});
      qb.push_back('{due: cyc + 3, dma: 1'b1, addr: dma_addr});
    end
    if (m_burst) begin
      if (!dma_req) begin
        m_burst = 0; m_beats = 0;
      end else begin
        m_beats++;
        if (dma_last || m_beats == MAXB) begin
          m_burst = 0; m_beats = 0;
        end
      end
    end else if (e_dg && !dma_last && MAXB > 1) begin
      m_burst = 1; m_beats = 1;
    end
    if (e_cg) m_last_dma = 0;
    if (e_dg) m_last_dma = 1;
  endtask

  task automatic chk_port(input string p, input logic cg, dg, en, we,
                          input logic [31:0] addr, wdata, input logic crv, drv,
                          input logic [31:0] crd, drd,
                          input bit ev, ed, input logic [31:0] er);
    chk({p, "_core_gnt"}, cg, e_cg);
    chk({p, "_dma_gnt"}, dg, e_dg);
    chk({p, "_mem_en"}, en, e_cg | e_dg);
    if (e_cg || e_dg) begin
      chk({p, "_mem_we"}, we, e_dg ? dma_we : core_we);
      chk({p, "_mem_addr"}, addr, e_dg ? dma_addr : core_addr);
      if (e_dg ? dma_we : core_we) chk({p, "_mem_wdata"}, wdata, e_dg ? dma_wdata : core_wdata);
    end
    chk({p, "_core_rvalid"}, crv, ev && !ed);
    chk({p, "_dma_rvalid"}, drv, ev && ed);
    if (ev) begin
      chk({p, "_core_rdata"}, crd, er);
      chk({p, "_dma_rdata"}, drd, er);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    bit ev, ed;
    logic [31:0] er;
    @(negedge clk);
    if (rst) begin
      qa.delete(); qb.delete();
    end
    model_gnt();
    ev = 0; ed = 0; er = '0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      ev = 1; ed = qa[0].dma; er = mem_val(qa[0].addr); void'(qa.pop_front());
    end
    chk_port("a", a_cg, a_dg, a_en, a_we, a_addr, a_wdata, a_crv, a_drv, a_crd, a_drd, ev, ed, er);
    ev = 0; ed = 0; er = '0;
    if (qb.size() > 0 && qb[0].due == cyc) begin
      ev = 1; ed = qb[0].dma; er = mem_val(qb[0].addr); void'(qb.pop_front());
    end
    chk_port("b", b_cg, b_dg, b_en, b_we, b_addr, b_wdata, b_crv, b_drv, b_crd, b_drd, ev, ed, er);
    obs_cg = a_cg; obs_dg = a_dg; obs_crv = a_crv; obs_drv = a_drv; obs_crd = a_crd;
    if (b_crv === 1'b1) cnt_bc++;
    if (b_drv === 1'b1) cnt_bd++;
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] hist_d, hist_c;
    int idx;
    bit cp, dp;
    n_checks = 0; n_fail = 0; cyc = 0; cnt_bc = 0; cnt_bd = 0;
    m_burst = 0; m_beats = 0; m_last_dma = 1;
    // Requests held high during reset must not be granted.
    rst = 1'b1;
    core_req = 1; core_we = 0; core_addr = 32'h40; core_wdata = '0;
    dma_req = 1; dma_we = 0; dma_last = 0; dma_addr = 32'h80; dma_wdata = '0;
    #1;
    cycle();
    cycle();
    chk("reset_gnt", {obs_cg, obs_dg}, 2'b00);
    core_req = 0; dma_req = 0;
    rst = 1'b0;

    // 1: core-only read of 0x100.
    core_req = 1; core_we = 0; core_addr = 32'h100;
    cycle();
    chk("t1_gnt", obs_cg, 1'b1);
    core_req = 0;
    cycle();
    chk("t1_rvalid", obs_crv, 1'b1);
    chk("t1_rdata", obs_crd, 32'hDEADBEEF);
    chk("t1_dma_rvalid", obs_drv, 1'b0);

    // 2: tie out of reset goes to core, then alternates.
    do_reset();
    core_req = 1; core_addr = 32'h200; dma_req = 1; dma_we = 0; dma_last = 1; dma_addr = 32'h300;
    cycle();
    chk("t2_first", {obs_cg, obs_dg}, 2'b10);
    core_addr = 32'h204;
    cycle();
    chk("t2_second", {obs_cg, obs_dg}, 2'b01);
    dma_req = 0;
    cycle();
    chk("t2_third", {obs_cg, obs_dg}, 2'b10);

    // 3: 4-beat DMA write burst with core waiting throughout.
    core_addr = 32'h208; core_we = 1; core_wdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      dma_req = 1; dma_we = 1; dma_last = (i == 3);
      dma_addr = 32'h1000 + 32'(4 * i); dma_wdata = 32'hA000_0000 + 32'(i);
      cycle();
      chk("t3_beat", {obs_cg, obs_dg}, 2'b01);
    end
    dma_req = 0;
    cycle();
    chk("t3_core", {obs_cg, obs_dg}, 2'b10);

    // 4: 12-beat DMA read stream without dma_last; core breaks in after MAX_BURST beats.
    cp = 1; idx = 0; hist_d = '0; hist_c = '0;
    core_we = 0; core_addr = 32'h400; dma_we = 0; dma_last = 0;
    for (int i = 0; i < 16; i++) begin
      dma_req = (idx < 12); dma_addr = 32'h2000 + 32'(4 * idx);
      core_req = cp;
      cycle();
      hist_d[i] = obs_dg; hist_c[i] = obs_cg;
      if (e_dg) idx++;
      if (e_cg) cp = 0;
    end
    chk("t4_dma_hist", {16'h0, hist_d}, 32'h1EFF);
    chk("t4_core_hist", {16'h0, hist_c}, 32'h0100);

    // 5: alternating reads, checked on both latencies; count returns on the MEM_LAT=3 part.
    cnt_bc = 0; cnt_bd = 0;
    for (int i = 0; i < 8; i++) begin
      core_req = 1; core_we = 0; core_addr = 32'h3000 + 32'(4 * i);
      dma_req = 1; dma_we = 0; dma_last = 1; dma_addr = 32'h5000 + 32'(4 * i);
      cycle();
    end
    core_req = 0; dma_req = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("t5_core_returns", cnt_bc, 4);
    chk("t5_dma_returns", cnt_bd, 4);

    // 6: reset with reads in flight in the middle of a DMA burst.
    for (int i = 0; i < 5; i++) begin
      dma_req = 1; dma_we = 0; dma_last = 0; dma_addr = 32'h6000 + 32'(4 * i);
      cycle();
    end
    rst = 1; core_req = 1; core_addr = 32'h700; dma_req = 1;
    cnt_bc = 0; cnt_bd = 0;
    cycle();
    cycle();
    rst = 0;
    cycle();
    chk("t6_tie_core", {obs_cg, obs_dg}, 2'b10);
    core_req = 0; dma_req = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("t6_dma_returns", cnt_bd, 0);

    // Random traffic with occasional reset pulses.
    cp = 0; dp = 0; core_req = 0; dma_req = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!cp && $urandom_range(0, 2) != 0) begin
        cp = 1; core_we = $urandom_range(0, 1) == 1;
        core_addr = ($urandom_range(0, 7) == 0) ? 32'h100 : $urandom();
        core_wdata = $urandom();
      end
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1; dma_we = $urandom_range(0, 1) == 1; dma_last = $urandom_range(0, 5) == 0;
        dma_addr = $urandom(); dma_wdata = $urandom();
      end
      core_req = cp; dma_req = dp;
      rst = ($urandom_range(0, 399) == 0);
      cycle();
      if (e_cg) cp = 0;
      if (e_dg) dp = 0;
    end
    rst = 0; core_req = 0; dma_req = 0;
    for (int i = 0; i < 4; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
